// File: rtl/jtframe_rom_dwnld_router.sv
// jtframe_rom_dwnld_router
// Takes the byte-wide ROM download stream and turns it into SDRAM bank write
// requests. The first HEADER bytes are not written; the first four of them are
// kept on the header port. Requests are held until the controller accepts them.
// A one-entry skid buffer absorbs a byte that arrives while a write is pending.
// dwnld_busy keeps the game in reset until the last byte is committed, and then
// for LINGER more cycles.
module jtframe_rom_dwnld_router #(
  parameter int unsigned HEADER    = 0,
  parameter logic [24:0] BA1_START = 25'h10_0000,
  parameter logic [24:0] BA2_START = 25'h18_0000,
  parameter logic [24:0] BA3_START = 25'h1C_0000,
  parameter bit          SWAB      = 1'b0,
  parameter int unsigned LINGER    = 256
) (
  input  logic        clk_rom,
  input  logic        rst,
  input  logic        downloading,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_data,
  input  logic        ioctl_rom_wr,
  output logic [21:0] prog_addr,
  output logic [7:0]  prog_data,
  output logic [1:0]  prog_mask,
  output logic [1:0]  prog_bank,
  output logic        prog_we,
  input  logic        prog_rdy,
  output logic [31:0] header,
  output logic        dwnld_busy,
  output logic        overflow
);

  // The linger counter gets one extra bit when LINGER does not fit in eight.
  localparam int unsigned   CW       = (LINGER > 255) ? 9 : 8;
  localparam logic [24:0]   HEADER_W = 25'(HEADER);
  localparam logic [CW-1:0] LINGER_W = CW'(LINGER);
  localparam logic [CW-1:0] ONE_C    = CW'(1);
  localparam logic [CW-1:0] ZERO_C   = CW'(0);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  typedef struct packed {
    logic [21:0] addr;
    logic [7:0]  data;
    logic [1:0]  mask;
    logic [1:0]  bank;
  } req_t;

  localparam logic [33:0] REQ_ZERO = 34'd0;

  state_t          state_q, state_d;
  req_t            out_q, out_d;
  req_t            skid_q, skid_d;
  logic            skid_full_q, skid_full_d;
  logic            prog_we_q, prog_we_d;
  logic [31:0]     header_q, header_d;
  logic            overflow_q, overflow_d;
  logic            busy_q, busy_d;
  logic [CW-1:0]   linger_q, linger_d;
  logic            dl_q, dl_d;

  logic            strobe_s;
  logic [25:0]     hdr_diff_s;
  logic            in_hdr_s;
  logic [24:0]     eff_s;
  logic [24:0]     start_s;
  logic [1:0]      bank_s;
  logic [24:0]     off_s;
  logic            lane_s;
  logic            range_err_s;
  logic            hdr_wr_s;
  logic            req_valid_s;
  logic            range_drop_s;
  logic            fifo_drop_s;
  logic            pending_s;
  req_t            req_s;

  // Decode an incoming byte: header or data, target bank, word address, lane.
  always_comb begin
    strobe_s   = ioctl_rom_wr & downloading;
    // The borrow of addr - HEADER tells whether the byte lies in the header.
    hdr_diff_s = {1'b0, ioctl_addr} - {1'b0, HEADER_W};
    in_hdr_s   = hdr_diff_s[25];
    eff_s      = hdr_diff_s[24:0];
    if (eff_s >= BA3_START) begin
      bank_s  = 2'd3;
      start_s = BA3_START;
    end else if (eff_s >= BA2_START) begin
      bank_s  = 2'd2;
      start_s = BA2_START;
    end else if (eff_s >= BA1_START) begin
      bank_s  = 2'd1;
      start_s = BA1_START;
    end else begin
      bank_s  = 2'd0;
      start_s = 25'd0;
    end
    off_s        = eff_s - start_s;
    lane_s       = off_s[0] ^ SWAB;
    range_err_s  = (off_s[24:23] != 2'b00);
    req_s.addr   = off_s[22:1];
    req_s.data   = ioctl_data;
    req_s.mask   = lane_s ? 2'b01 : 2'b10;
    req_s.bank   = bank_s;
    hdr_wr_s     = strobe_s & in_hdr_s & (ioctl_addr[24:2] == 23'd0);
    req_valid_s  = strobe_s & ~in_hdr_s & ~range_err_s;
    range_drop_s = strobe_s & ~in_hdr_s & range_err_s;
    pending_s    = (state_q == ST_WAIT) | skid_full_q;
  end

  // Write FSM: output register load, handshake with prog_rdy, skid buffer.
  always_comb begin
    state_d     = state_q;
    out_d       = out_q;
    skid_d      = skid_q;
    skid_full_d = skid_full_q;
    prog_we_d   = prog_we_q;
    fifo_drop_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid_s) begin
          out_d     = req_s;
          prog_we_d = 1'b1;
          state_d   = ST_WAIT;
        end else begin
          prog_we_d = 1'b0;
          state_d   = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (prog_rdy) begin
          if (skid_full_q) begin
            // Buffered byte moves out; a same-cycle strobe refills the buffer.
            out_d     = skid_q;
            prog_we_d = 1'b1;
            if (req_valid_s) begin
              skid_d      = req_s;
              skid_full_d = 1'b1;
            end else begin
              skid_full_d = 1'b0;
            end
          end else if (req_valid_s) begin
            // Back-to-back write with no idle cycle on prog_we.
            out_d     = req_s;
            prog_we_d = 1'b1;
          end else begin
            prog_we_d = 1'b0;
            state_d   = ST_IDLE;
          end
        end else if (req_valid_s) begin
          if (skid_full_q) begin
            fifo_drop_s = 1'b1;
          end else begin
            skid_d      = req_s;
            skid_full_d = 1'b1;
          end
        end else begin
          prog_we_d = 1'b1;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        prog_we_d   = 1'b0;
        skid_full_d = 1'b0;
      end
    endcase
  end

  // Header capture, sticky overflow flag and the busy/linger timer.
  always_comb begin
    header_d = header_q;
    dl_d     = downloading;
    if (hdr_wr_s) begin
      case (ioctl_addr[1:0])
        2'd0:    header_d[7:0]   = ioctl_data;
        2'd1:    header_d[15:8]  = ioctl_data;
        2'd2:    header_d[23:16] = ioctl_data;
        default: header_d[31:24] = ioctl_data;
      endcase
    end else begin
      header_d = header_q;
    end
    // A drop wins over the clear so a byte lost on the first cycle is reported.
    if (range_drop_s || fifo_drop_s) begin
      overflow_d = 1'b1;
    end else if (downloading && !dl_q) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
    if (downloading || pending_s) begin
      linger_d = LINGER_W;
      busy_d   = 1'b1;
    end else if (linger_q != ZERO_C) begin
      linger_d = linger_q - ONE_C;
      busy_d   = (linger_q != ONE_C);
    end else begin
      linger_d = ZERO_C;
      busy_d   = 1'b0;
    end
  end

  // All state registers; rst abandons any pending write immediately.
  always_ff @(posedge clk_rom or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      out_q       <= REQ_ZERO;
      skid_q      <= REQ_ZERO;
      skid_full_q <= 1'b0;
      prog_we_q   <= 1'b0;
      header_q    <= 32'd0;
      overflow_q  <= 1'b0;
      busy_q      <= 1'b0;
      linger_q    <= ZERO_C;
      dl_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_q       <= out_d;
      skid_q      <= skid_d;
      skid_full_q <= skid_full_d;
      prog_we_q   <= prog_we_d;
      header_q    <= header_d;
      overflow_q  <= overflow_d;
      busy_q      <= busy_d;
      linger_q    <= linger_d;
      dl_q        <= dl_d;
    end
  end

  assign prog_addr  = out_q.addr;
  assign prog_data  = out_q.data;
  assign prog_mask  = out_q.mask;
  assign prog_bank  = out_q.bank;
  assign prog_we    = prog_we_q;
  assign header     = header_q;
  assign dwnld_busy = busy_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_jtframe_rom_dwnld_router.sv
// Testbench for jtframe_rom_dwnld_router. Three instances share one stimulus:
//   u0: HEADER=0, SWAB=0, LINGER=4
//   u1: HEADER=2, SWAB=0, LINGER=256
//   u2: HEADER=0, SWAB=1, LINGER=256
// A queue-level reference model checks every instance each cycle, while
// directed sequences and a decode table check specific scenarios.
module tb_jtframe_rom_dwnld_router;

  logic        clk_rom = 1'b0;
  logic        rst;
  logic        downloading;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_data;
  logic        ioctl_rom_wr;
  logic        prog_rdy;

  logic [21:0] pa [3];
  logic [7:0]  pd [3];
  logic [1:0]  pm [3];
  logic [1:0]  pb [3];
  logic        pw [3];
  logic [31:0] hd [3];
  logic        busy [3];
  logic        ovf [3];

  always #5 clk_rom = ~clk_rom;

  jtframe_rom_dwnld_router #(.HEADER(0), .SWAB(1'b0), .LINGER(4)) u0 (
    .clk_rom(clk_rom), .rst(rst), .downloading(downloading),
    .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data), .ioctl_rom_wr(ioctl_rom_wr),
    .prog_addr(pa[0]), .prog_data(pd[0]), .prog_mask(pm[0]), .prog_bank(pb[0]),
    .prog_we(pw[0]), .prog_rdy(prog_rdy), .header(hd[0]),
    .dwnld_busy(busy[0]), .overflow(ovf[0]));

  jtframe_rom_dwnld_router #(.HEADER(2), .SWAB(1'b0), .LINGER(256)) u1 (
    .clk_rom(clk_rom), .rst(rst), .downloading(downloading),
    .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data), .ioctl_rom_wr(ioctl_rom_wr),
    .prog_addr(pa[1]), .prog_data(pd[1]), .prog_mask(pm[1]), .prog_bank(pb[1]),
    .prog_we(pw[1]), .prog_rdy(prog_rdy), .header(hd[1]),
    .dwnld_busy(busy[1]), .overflow(ovf[1]));

  jtframe_rom_dwnld_router #(.HEADER(0), .SWAB(1'b1), .LINGER(256)) u2 (
    .clk_rom(clk_rom), .rst(rst), .downloading(downloading),
    .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data), .ioctl_rom_wr(ioctl_rom_wr),
    .prog_addr(pa[2]), .prog_data(pd[2]), .prog_mask(pm[2]), .prog_bank(pb[2]),
    .prog_we(pw[2]), .prog_rdy(prog_rdy), .header(hd[2]),
    .dwnld_busy(busy[2]), .overflow(ovf[2]));

  typedef struct packed {
    logic [21:0] addr;
    logic [7:0]  data;
    logic [1:0]  mask;
    logic [1:0]  bank;
  } wr_t;

  typedef struct {
    logic [24:0] addr;
    logic [7:0]  data;
    bit          valid;
    logic [1:0]  bank;
    logic [21:0] paddr;
    logic [1:0]  mask;
  } vec_t;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state per instance: held writes (outputs first, then buffer).
  wr_t         m_q    [3][2];
  int          m_cnt  [3];
  logic [31:0] m_hdr  [3];
  logic        m_ovf  [3];
  int          m_idle [3];
  logic        m_dlp  [3];

  function automatic int unsigned hdr_of(input int i);
    return (i == 1) ? 32'd2 : 32'd0;
  endfunction

  function automatic int unsigned swab_of(input int i);
    return (i == 2) ? 32'd1 : 32'd0;
  endfunction

  function automatic int linger_of(input int i);
    return (i == 0) ? 4 : 256;
  endfunction

  task automatic chk(input string name, input int inst, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s u%0d at %0t: got %h, expected %h", name, inst, $time, act, exp);
    end
  endtask

  // Byte classification and address mapping from the plain arithmetic rules.
  function automatic void decode(input int i, input logic [24:0] a, input logic [7:0] d,
                                 output bit is_hdr, output bit is_err, output wr_t w);
    int unsigned av, eff, start, off, b, lane;
    av     = 32'(a);
    is_hdr = av < hdr_of(i);
    eff    = av - hdr_of(i);
    if (eff >= 32'h1C_0000)      begin b = 3; start = 32'h1C_0000; end
    else if (eff >= 32'h18_0000) begin b = 2; start = 32'h18_0000; end
    else if (eff >= 32'h10_0000) begin b = 1; start = 32'h10_0000; end
    else                         begin b = 0; start = 0; end
    off    = eff - start;
    is_err = off >= 32'h80_0000;
    lane   = (off % 2) ^ swab_of(i);
    w.addr = 22'(off / 2);
    w.data = d;
    w.mask = (lane != 0) ? 2'b01 : 2'b10;
    w.bank = 2'(b);
  endfunction

  task automatic sb_update(input int i);
    bit  is_hdr, is_err, active, drop;
    wr_t w;
    if (rst) begin
      m_cnt[i]  = 0;
      m_hdr[i]  = 32'd0;
      m_ovf[i]  = 1'b0;
      m_idle[i] = 1000;
      m_dlp[i]  = 1'b0;
      return;
    end
    active    = downloading || (m_cnt[i] > 0);
    m_idle[i] = active ? 0 : ((m_idle[i] < 1000) ? m_idle[i] + 1 : 1000);
    decode(i, ioctl_addr, ioctl_data, is_hdr, is_err, w);
    drop = 1'b0;
    if (prog_rdy && m_cnt[i] > 0) begin
      m_q[i][0] = m_q[i][1];
      m_cnt[i]--;
    end
    if (ioctl_rom_wr && downloading) begin
      if (is_hdr) begin
        if (ioctl_addr < 25'd4) m_hdr[i][8*ioctl_addr[1:0] +: 8] = ioctl_data;
      end else if (is_err) begin
        drop = 1'b1;
      end else if (m_cnt[i] < 2) begin
        m_q[i][m_cnt[i]] = w;
        m_cnt[i]++;
      end else begin
        drop = 1'b1;
      end
    end
    if (drop) m_ovf[i] = 1'b1;
    else if (downloading && !m_dlp[i]) m_ovf[i] = 1'b0;
    m_dlp[i] = downloading;
  endtask

  task automatic sb_check(input int i);
    chk("sb_we", i, 64'(pw[i]), 64'(m_cnt[i] > 0));
    if (m_cnt[i] > 0) chk("sb_out", i, 64'({pa[i], pd[i], pm[i], pb[i]}), 64'(m_q[i][0]));
    chk("sb_header", i, 64'(hd[i]), 64'(m_hdr[i]));
    chk("sb_busy", i, 64'(busy[i]), 64'(m_idle[i] < linger_of(i)));
    chk("sb_overflow", i, 64'(ovf[i]), 64'(m_ovf[i]));
  endtask

  // Scoreboard: inputs change only 1 time unit after a falling edge, so at the
  // falling edge they still hold the values the DUT sampled on the last rise.
  initial begin
    forever begin
      @(negedge clk_rom);
      for (int i = 0; i < 3; i++) begin
        sb_update(i);
        sb_check(i);
      end
    end
  end

  task automatic step();
    @(negedge clk_rom);
    #1;
  endtask

  function automatic logic [24:0] rand_addr();
    logic [24:0] base;
    case ($urandom_range(0, 6))
      0:       base = 25'h00_0000;
      1:       base = 25'h0F_FFFC;
      2:       base = 25'h17_FFFC;
      3:       base = 25'h1B_FFFC;
      4:       base = 25'h9B_FFFC;
      5:       base = 25'($urandom);
      default: base = 25'($urandom_range(0, 32'h1F_FFFF));
    endcase
    return base + 25'($urandom_range(0, 7));
  endfunction

  task automatic restart_download();
    downloading = 1'b0;
    step();
    downloading = 1'b1;
    step();
  endtask

  vec_t tbl [10];
  int   we_cnt;
  int   hi_cnt;

  initial begin
    tbl[0] = '{25'h000_0000, 8'h01, 1'b1, 2'd0, 22'h00_0000, 2'b10};
    tbl[1] = '{25'h000_0001, 8'h02, 1'b1, 2'd0, 22'h00_0000, 2'b01};
    tbl[2] = '{25'h00F_FFFF, 8'h03, 1'b1, 2'd0, 22'h07_FFFF, 2'b01};
    tbl[3] = '{25'h010_0000, 8'h04, 1'b1, 2'd1, 22'h00_0000, 2'b10};
    tbl[4] = '{25'h017_FFFE, 8'h05, 1'b1, 2'd1, 22'h03_FFFF, 2'b10};
    tbl[5] = '{25'h018_0001, 8'h06, 1'b1, 2'd2, 22'h00_0000, 2'b01};
    tbl[6] = '{25'h01C_0005, 8'h07, 1'b1, 2'd3, 22'h00_0002, 2'b01};
    tbl[7] = '{25'h09B_FFFF, 8'h08, 1'b1, 2'd3, 22'h3F_FFFF, 2'b01};
    tbl[8] = '{25'h09C_0000, 8'h09, 1'b0, 2'd0, 22'h00_0000, 2'b00};
    tbl[9] = '{25'h1FF_FFFF, 8'h0A, 1'b0, 2'd0, 22'h00_0000, 2'b00};

    rst = 1'b1; downloading = 1'b0; ioctl_addr = 25'd0; ioctl_data = 8'd0;
    ioctl_rom_wr = 1'b0; prog_rdy = 1'b0;
    step(); step();
    for (int i = 0; i < 3; i++) begin
      chk("reset_outputs", i, 64'({pa[i], pd[i], pm[i], pb[i], pw[i]}), 64'd0);
      chk("reset_status", i, 64'({hd[i], busy[i], ovf[i]}), 64'd0);
    end
    rst = 1'b0;
    downloading = 1'b1;
    step();
    chk("busy_on_download", 0, 64'(busy[0]), 64'd1);

    // Header stripping on u1; lane swap on u2 for the byte at address 0.
    prog_rdy = 1'b1;
    ioctl_addr = 25'd0; ioctl_data = 8'hAA; ioctl_rom_wr = 1'b1;
    step();
    chk("hdr_no_write_aa", 1, 64'(pw[1]), 64'd0);
    chk("swab_mask", 2, 64'({pw[2], pm[2]}), 64'({1'b1, 2'b01}));
    ioctl_addr = 25'd1; ioctl_data = 8'hBB;
    step();
    chk("hdr_no_write_bb", 1, 64'(pw[1]), 64'd0);
    chk("hdr_bytes", 1, 64'(hd[1][15:0]), 64'(16'hBBAA));
    ioctl_addr = 25'd2; ioctl_data = 8'hCC;
    step();
    ioctl_rom_wr = 1'b0;
    chk("hdr_first_write", 1, 64'({pw[1], pa[1], pd[1], pm[1], pb[1]}),
        64'({1'b1, 22'd0, 8'hCC, 2'b10, 2'd0}));
    step();
    chk("hdr_write_done", 1, 64'(pw[1]), 64'd0);
    prog_rdy = 1'b0;

    // Bank 1 write held for three cycles until prog_rdy.
    ioctl_addr = 25'h10_0003; ioctl_data = 8'h5A; ioctl_rom_wr = 1'b1;
    step();
    ioctl_rom_wr = 1'b0;
    chk("bank1_write", 0, 64'({pa[0], pd[0], pm[0], pb[0]}), 64'({22'd1, 8'h5A, 2'b01, 2'd1}));
    we_cnt = int'(pw[0]);
    step(); we_cnt += int'(pw[0]);
    step(); we_cnt += int'(pw[0]);
    prog_rdy = 1'b1;
    step(); we_cnt += int'(pw[0]);
    prog_rdy = 1'b0;
    step(); we_cnt += int'(pw[0]);
    chk("we_hold_cycles", 0, 64'(we_cnt), 64'd3);

    // Decode table: one write per entry, drained with a single prog_rdy pulse.
    for (int k = 0; k < 10; k++) begin
      ioctl_addr = tbl[k].addr; ioctl_data = tbl[k].data; ioctl_rom_wr = 1'b1;
      step();
      ioctl_rom_wr = 1'b0;
      chk("tbl_we", k, 64'(pw[0]), 64'(tbl[k].valid));
      if (tbl[k].valid)
        chk("tbl_out", k, 64'({pa[0], pd[0], pm[0], pb[0]}),
            64'({tbl[k].paddr, tbl[k].data, tbl[k].mask, tbl[k].bank}));
      else
        chk("tbl_overflow", k, 64'(ovf[0]), 64'd1);
      prog_rdy = 1'b1;
      step();
      prog_rdy = 1'b0;
    end
    restart_download();
    chk("overflow_cleared", 0, 64'(ovf[0]), 64'd0);

    // Three strobes with no accept: outputs, buffer, drop.
    ioctl_addr = 25'h10; ioctl_data = 8'h11; ioctl_rom_wr = 1'b1;
    step();
    ioctl_addr = 25'h12; ioctl_data = 8'h22;
    step();
    ioctl_addr = 25'h14; ioctl_data = 8'h33;
    step();
    ioctl_rom_wr = 1'b0;
    chk("skid_overflow", 0, 64'(ovf[0]), 64'd1);
    chk("skid_first", 0, 64'({pw[0], pd[0], pa[0]}), 64'({1'b1, 8'h11, 22'h8}));
    prog_rdy = 1'b1;
    step();
    prog_rdy = 1'b0;
    chk("skid_second", 0, 64'({pw[0], pd[0], pa[0]}), 64'({1'b1, 8'h22, 22'h9}));
    prog_rdy = 1'b1;
    step();
    prog_rdy = 1'b0;
    chk("skid_drained", 0, 64'(pw[0]), 64'd0);
    restart_download();

    // Strobe together with prog_rdy while the buffer is empty.
    ioctl_addr = 25'h20; ioctl_data = 8'h44; ioctl_rom_wr = 1'b1;
    step();
    ioctl_addr = 25'h22; ioctl_data = 8'h55; prog_rdy = 1'b1;
    step();
    ioctl_rom_wr = 1'b0; prog_rdy = 1'b0;
    chk("no_bubble", 0, 64'({pw[0], pa[0], pd[0]}), 64'({1'b1, 22'h11, 8'h55}));
    prog_rdy = 1'b1;
    step();
    prog_rdy = 1'b0;
    chk("no_bubble_done", 0, 64'(pw[0]), 64'd0);

    // Linger: download ends with a write pending, accepted two cycles later.
    ioctl_addr = 25'h30; ioctl_data = 8'h66; ioctl_rom_wr = 1'b1;
    step();
    ioctl_rom_wr = 1'b0; downloading = 1'b0;
    step();
    prog_rdy = 1'b1;
    step();
    prog_rdy = 1'b0;
    chk("linger_drained", 0, 64'(pw[0]), 64'd0);
    hi_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      if (busy[0]) hi_cnt++;
      step();
    end
    chk("linger_cycles", 0, 64'(hi_cnt), 64'd4);
    chk("linger_long_busy", 1, 64'(busy[1]), 64'd1);
    downloading = 1'b1;
    step();

    // Reset in the middle of a pending write with overflow set.
    for (int k = 0; k < 3; k++) begin
      ioctl_addr = 25'(64 + 2 * k); ioctl_data = 8'(k); ioctl_rom_wr = 1'b1;
      step();
    end
    ioctl_rom_wr = 1'b0;
    chk("pre_rst_we", 0, 64'({pw[0], ovf[0]}), 64'({1'b1, 1'b1}));
    #1 rst = 1'b1;
    #1;
    for (int i = 0; i < 3; i++)
      chk("rst_immediate", i, 64'({pw[i], busy[i], ovf[i]}), 64'd0);
    step();
    rst = 1'b0;
    step();
    chk("post_rst_we", 0, 64'(pw[0]), 64'd0);

    // Randomized traffic, checked by the scoreboard every cycle.
    for (int k = 0; k < 1500; k++) begin
      downloading  = ($urandom_range(0, 15) != 0);
      ioctl_rom_wr = ($urandom_range(0, 2) == 0);
      prog_rdy     = ($urandom_range(0, 2) == 0);
      ioctl_addr   = rand_addr();
      ioctl_data   = 8'($urandom);
      step();
    end
    ioctl_rom_wr = 1'b0; prog_rdy = 1'b1; downloading = 1'b0;
    for (int k = 0; k < 300; k++) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
